// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared state encoding, counter width and ms-to-cycles helper
package button_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        PRESSED  = 3'd2,
        HELD     = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] ms_to_cycles(input int unsigned freq, input int unsigned ms);
        return (freq / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - raw button input and conditioned event outputs
interface button_debounce_if;

    logic btn_n;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;
    logic btn_repeat;

    // master is the board/user side, slave is the debouncer
    modport master (
        output btn_n,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_repeat
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_repeat
    );

endinterface

// File: rtl/button_debounce_btn_sync.sv
// rtl/button_debounce_btn_sync.sv - two-flop synchroniser with configurable reset value
module btn_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button debouncer with press/release/long pulses; BTN_REPEAT_EN adds auto-repeat
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 20000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic             clk,
    input  logic             reset,
    button_debounce_if.slave btn
);

    localparam logic [CNT_W-1:0] DB_CYC    = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] LONG_CYC  = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam logic [CNT_W-1:0] REP_CYC   = ms_to_cycles(CLK_FREQ, REPEAT_MS);
    localparam logic [CNT_W-1:0] DB_LAST   = DB_CYC - 1'b1;
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYC - 1'b1;
    localparam logic [CNT_W-1:0] REP_LAST  = REP_CYC - 1'b1;

    logic             w_sync_n;
    logic             w_btn_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_long_done;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;

    // Sync flops reset to 1 so a held button after reset looks like a fresh press
    btn_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (btn.btn_n),
        .o_q   (w_sync_n)
    );

    assign w_btn_s = ~w_sync_n;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) w_state_nxt = DB_PRESS;
            end
            DB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = PRESSED;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = DB_REL;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = HELD;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = DB_REL;
                end
`ifdef BTN_REPEAT_EN
                else if (r_cnt == REP_LAST) begin
                    w_repeat_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            DB_REL: begin
                // A bounce during release resumes the hold; long fires at most once per press
                if (w_btn_s) begin
                    w_state_nxt = r_long_done ? HELD : PRESSED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_level   <= (w_state_nxt == PRESSED) || (w_state_nxt == HELD) || (w_state_nxt == DB_REL);
            if (w_state_nxt == HELD) begin
                r_long_done <= 1'b1;
            end else if (w_state_nxt == IDLE) begin
                r_long_done <= 1'b0;
            end
        end
    end

    assign btn.btn_level   = r_level;
    assign btn.btn_press   = r_press;
    assign btn.btn_release = r_release;
    assign btn.btn_long    = r_long;

`ifdef BTN_REPEAT_EN
    logic r_repeat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat_nxt;
        end
    end

    assign btn.btn_repeat = r_repeat;
`else
    logic w_unused_rep;

    assign w_unused_rep   = ^{REP_LAST, w_repeat_nxt};
    assign btn.btn_repeat = 1'b0;
`endif

endmodule
